pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset (word-aligned).
REQ-002 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum S_WAIT cycles before a fetch is retried (range 2..255).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-005 The block SHALL have port stop, input, 1, meaning the control-FSM busy flag; 1 means the instruction is in progress.
REQ-006 The block SHALL have ports Jump, input, 1 and Branch, input, 1, meaning the control-FSM jump and branch requests.
REQ-007 The block SHALL have port Zero, input, 1, meaning the ALU equality result that qualifies Branch.
REQ-008 The block SHALL have ports imem_req, output, 1 and imem_addr, output, 32, meaning the instruction-memory read request and its byte address.
REQ-009 The block SHALL have ports imem_rdata, input, 32 and imem_valid, input, 1, meaning the instruction-memory read data and its 1-cycle data-valid strobe.
REQ-010 The block SHALL have ports OpCode, output, 6 and instr, output, 32, meaning IR[31:26] and the full instruction register.
REQ-011 The block SHALL have ports pc, output, 32 and instr_valid, output, 1, meaning the current PC and the IR-holds-fetched-instruction flag.
REQ-012 The block SHALL have port fetch_err, output, 1, meaning a 1-cycle pulse on each fetch timeout.

Function
REQ-013 The FSM SHALL have states S_REQ, S_WAIT and S_HOLD, and every state SHALL be registered.
REQ-014 S_REQ: imem_req=1 and imem_addr=pc for exactly one cycle, followed by an unconditional move to S_WAIT with the wait counter cleared.
REQ-015 S_WAIT: imem_req=0; the counter increments each cycle; imem_valid=1 latches imem_rdata into IR and moves to S_HOLD.
REQ-016 instr_valid SHALL be 1 from the cycle after the IR latch until the cycle after completion; it SHALL be 0 in S_REQ and S_WAIT.
REQ-017 imem_valid SHALL be ignored in S_REQ and S_HOLD.
REQ-018 S_HOLD: IR and pc SHALL stay stable while awaiting completion, defined as stop_q==1 and stop==0, where stop_q is stop registered one cycle.
REQ-019 At completion, with pc4 = pc+4, the next pc SHALL be as follows. Jump=1 gives {pc4[31:28], IR[25:0], 2'b00}. Else Branch=1 and Zero=1 gives pc4 + (sign-extended IR[15:0] << 2). Otherwise it is pc4. The FSM then moves to S_REQ.
REQ-020 Jump SHALL take priority over Branch when both are 1 at completion.
REQ-021 Jump, Branch and Zero SHALL be sampled only in the completion cycle.
REQ-022 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC+4 gives 32'h0000_0000, and branch underflow wraps the same way.
REQ-023 A stop rise/fall that is not followed by a fall in S_HOLD SHALL keep the block in S_HOLD indefinitely.
REQ-024 A stop fall in S_REQ or S_WAIT SHALL NOT update pc.

Reset
REQ-025 While rst=1, the block SHALL hold pc=RESET_PC, state=S_REQ, IR=0, stop_q=0, counter=0, imem_req=0, instr_valid=0 and fetch_err=0.
REQ-026 imem_req SHALL assert in the first clock cycle after rst deasserts.
REQ-027 A reset during S_WAIT SHALL abandon the fetch, and the pc SHALL NOT advance.
REQ-028 Instruction memory SHALL be reset by the same rst, so no stale imem_valid arrives after reset.

Configuration
REQ-029 When FETCH_TIMEOUT_EN is defined, a counter reaching TIMEOUT-1 in S_WAIT with imem_valid=0 SHALL pulse fetch_err for 1 cycle and return to S_REQ with the same pc.
REQ-030 When FETCH_TIMEOUT_EN is defined, imem_valid on the timeout cycle SHALL win: IR latches, there is no error, and the FSM moves to S_HOLD.
REQ-031 When FETCH_TIMEOUT_EN is undefined, S_WAIT SHALL wait indefinitely, no counter logic SHALL be present, and fetch_err SHALL be tied 0.

Verification
REQ-032 Reset scenario: release rst with RESET_PC=0x100 -> next cycle imem_req=1 and imem_addr=0x100; imem_valid with 0x20080005 two cycles later -> OpCode=0x08 and instr_valid=1.
REQ-033 Sequential scenario: stop 0->1->1->0 with Jump=Branch=0 -> pc=0x104 and imem_req=1 the cycle after the fall.
REQ-034 Branch scenario: pc=0x100, IR imm=16'hFFFE, Branch=1, Zero=1 at the fall -> pc=0x0FC; with Zero=0 -> pc=0x104.
REQ-035 Jump scenario: pc=0x100, IR[25:0]=0x0000040, Jump=1 and Branch=1 at the fall -> pc=0x100 (jump target, jump wins).
REQ-036 Timeout and wrap scenario: with FETCH_TIMEOUT_EN and TIMEOUT=4, no imem_valid -> fetch_err pulse after 4 S_WAIT cycles and re-request at the same address; pc=0xFFFFFFFC sequential -> pc=0x00000000.
REQ-037 Mid-wait reset scenario: rst during S_WAIT -> pc=RESET_PC, instr_valid=0, and imem_req=1 the cycle after release.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction fetch sequencer.
// Issues a one-cycle read request at pc, captures the returned word into the
// instruction register, holds it until the control FSM signals completion
// (falling edge of stop), then advances pc sequentially or by jump/branch.
// Optional build macro FETCH_TIMEOUT_EN adds a wait-cycle limit that pulses
// fetch_err and re-issues the request at the same pc.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stop,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        Zero,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [5:0]  OpCode,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        instr_valid,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc_r;
  logic [31:0] ir;
  logic        stop_q;
  logic        req_r;
  logic        valid_r;
  logic        complete;
  logic [31:0] pc4;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic [31:0] next_pc;

  // TIMEOUT outside 2..255 is not a supported configuration.
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_unsupported
  end

  // Completion is a falling edge of stop seen while the instruction is held.
  assign complete = (state == S_HOLD) && stop_q && !stop;

  // Next-pc selection; jump outranks branch, arithmetic wraps modulo 2^32.
  always_comb begin
    pc4           = pc_r + 32'd4;
    jump_target   = {pc4[31:28], ir[25:0], 2'b00};
    branch_target = pc4 + {{14{ir[15]}}, ir[15:0], 2'b00};
    if (Jump) begin
      next_pc = jump_target;
    end else if (Branch && Zero) begin
      next_pc = branch_target;
    end else begin
      next_pc = pc4;
    end
  end

  // One-cycle delayed copy of stop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stop_q <= 1'b0;
    end else begin
      stop_q <= stop;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       err_r;

  // Fetch FSM with wait-cycle limit; a valid on the limit cycle still wins.
  // req_r is low in S_REQ only on the first cycle out of reset, which delays
  // the very first request by one clock so it never overlaps reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_REQ;
      pc_r     <= RESET_PC;
      ir       <= '0;
      req_r    <= 1'b0;
      valid_r  <= 1'b0;
      wait_cnt <= '0;
      err_r    <= 1'b0;
    end else begin
      err_r <= 1'b0;
      case (state)
        S_REQ: begin
          if (!req_r) begin
            req_r <= 1'b1;
          end else begin
            req_r    <= 1'b0;
            wait_cnt <= '0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (imem_valid) begin
            ir      <= imem_rdata;
            valid_r <= 1'b1;
            state   <= S_HOLD;
          end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
            err_r <= 1'b1;
            req_r <= 1'b1;
            state <= S_REQ;
          end
        end
        S_HOLD: begin
          if (complete) begin
            pc_r    <= next_pc;
            valid_r <= 1'b0;
            req_r   <= 1'b1;
            state   <= S_REQ;
          end
        end
        default: begin
          valid_r <= 1'b0;
          req_r   <= 1'b1;
          state   <= S_REQ;
        end
      endcase
    end
  end

  assign fetch_err = err_r;
`else
  // Fetch FSM; S_WAIT waits for imem_valid without limit.
  // req_r is low in S_REQ only on the first cycle out of reset, which delays
  // the very first request by one clock so it never overlaps reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_REQ;
      pc_r    <= RESET_PC;
      ir      <= '0;
      req_r   <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (!req_r) begin
            req_r <= 1'b1;
          end else begin
            req_r <= 1'b0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_valid) begin
            ir      <= imem_rdata;
            valid_r <= 1'b1;
            state   <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (complete) begin
            pc_r    <= next_pc;
            valid_r <= 1'b0;
            req_r   <= 1'b1;
            state   <= S_REQ;
          end
        end
        default: begin
          valid_r <= 1'b0;
          req_r   <= 1'b1;
          state   <= S_REQ;
        end
      endcase
    end
  end

  assign fetch_err = 1'b0;
`endif

  assign imem_req    = req_r;
  assign imem_addr   = pc_r;
  assign pc          = pc_r;
  assign instr       = ir;
  assign OpCode      = ir[31:26];
  assign instr_valid = valid_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: directed scenarios followed by randomized
// fetch/complete sequences checked against an arithmetic next-pc model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stop;
  logic        Jump;
  logic        Branch;
  logic        Zero;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [5:0]  OpCode;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_valid;
  logic        fetch_err;

  int errors = 0;
  int checks = 0;

  logic [31:0] mpc;
  logic [31:0] mir;

  pc_fetch_unit #(
    .RESET_PC(32'h0000_0100),
    .TIMEOUT (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stop       (stop),
    .Jump       (Jump),
    .Branch     (Branch),
    .Zero       (Zero),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .OpCode     (OpCode),
    .instr      (instr),
    .pc         (pc),
    .instr_valid(instr_valid),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Next pc from the instruction-set rules, in plain 64-bit arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] ir,
                                             input bit j, input bit b, input bit z);
    longint p4;
    longint off;
    p4 = (longint'(cur) + 64'sd4) % 64'sd4294967296;
    if (j) return 32'((p4 / 64'sd268435456) * 64'sd268435456 + (longint'(ir) % 64'sd67108864) * 64'sd4);
    if (b && z) begin
      off = longint'(ir) % 64'sd65536;
      if (off >= 64'sd32768) off = off - 64'sd65536;
      return 32'(p4 + off * 64'sd4);
    end
    return 32'(p4);
  endfunction

  task automatic noise_ctrl();
    Jump   = 1'($urandom_range(0, 1));
    Branch = 1'($urandom_range(0, 1));
    Zero   = 1'($urandom_range(0, 1));
  endtask

  // Entered at a negedge in S_REQ with the request visible; leaves in S_HOLD.
  task automatic fetch(input logic [31:0] data, input int delay);
    chk1("req_high", imem_req, 1'b1);
    chk("req_addr", imem_addr, mpc);
    chk1("req_iv", instr_valid, 1'b0);
    imem_valid = 1'($urandom_range(0, 1));
    imem_rdata = $urandom;
    stop       = 1'($urandom_range(0, 1));
    noise_ctrl();
    @(negedge clk);
    for (int k = 0; k <= delay; k++) begin
      chk1("wait_req", imem_req, 1'b0);
      chk1("wait_iv", instr_valid, 1'b0);
      chk1("wait_err", fetch_err, 1'b0);
      chk("wait_pc", pc, mpc);
      if (k == delay) begin
        imem_valid = 1'b1;
        imem_rdata = data;
        stop       = 1'b0;
      end else begin
        imem_valid = 1'b0;
        imem_rdata = $urandom;
        stop       = 1'($urandom_range(0, 1));
      end
      noise_ctrl();
      @(negedge clk);
    end
    mir = data;
    imem_valid = 1'($urandom_range(0, 1));
    imem_rdata = $urandom;
    chk("ir_latched", instr, mir);
    chk("opcode", {26'd0, OpCode}, mir >> 26);
    chk1("hold_iv", instr_valid, 1'b1);
    chk1("hold_req", imem_req, 1'b0);
  endtask

  // Entered in S_HOLD; stop low for pre cycles, high for hold cycles, then falls.
  task automatic complete(input int pre, input int hold, input bit j, input bit b, input bit z);
    logic [31:0] nxt;
    for (int i = 0; i < pre + hold; i++) begin
      chk("hold_pc", pc, mpc);
      chk("hold_ir", instr, mir);
      chk1("hold_iv_stable", instr_valid, 1'b1);
      chk1("hold_err", fetch_err, 1'b0);
      stop = (i >= pre);
      imem_valid = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      noise_ctrl();
      @(negedge clk);
    end
    chk("pre_done_pc", pc, mpc);
    stop   = 1'b0;
    Jump   = j;
    Branch = b;
    Zero   = z;
    imem_valid = 1'b0;
    nxt = model_next(mpc, mir, j, b, z);
    @(negedge clk);
    mpc = nxt;
    chk("next_pc", pc, mpc);
    chk1("next_req", imem_req, 1'b1);
    chk("next_addr", imem_addr, mpc);
    chk1("next_iv", instr_valid, 1'b0);
    noise_ctrl();
  endtask

  initial begin
    rst        = 1'b1;
    stop       = 1'b0;
    Jump       = 1'b0;
    Branch     = 1'b0;
    Zero       = 1'b0;
    imem_valid = 1'b0;
    imem_rdata = '0;
    mpc        = 32'h100;
    mir        = '0;
    repeat (3) @(negedge clk);
    chk("rst_pc", pc, 32'h100);
    chk("rst_ir", instr, 32'h0);
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_iv", instr_valid, 1'b0);
    chk1("rst_err", fetch_err, 1'b0);

    // Release reset; request appears on the first cycle after.
    rst = 1'b0;
    @(negedge clk);
    chk1("post_rst_req", imem_req, 1'b1);
    chk("post_rst_addr", imem_addr, 32'h100);

    fetch(32'h2008_0005, 1);
    chk("opcode_addi", {26'd0, OpCode}, 32'h08);

    complete(0, 2, 0, 0, 0);
    chk("seq_pc", pc, 32'h104);

    // Jump from 0x104 lands back on 0x100.
    fetch(32'h0800_0040, 0);
    complete(1, 1, 1, 1, 1);
    chk("jump_from_104", pc, 32'h100);

    // Jump and branch together at 0x100: jump wins.
    fetch(32'h0800_0040, 2);
    complete(0, 3, 1, 1, 1);
    chk("jump_wins", pc, 32'h100);

    // Taken backward branch.
    fetch(32'h1000_FFFE, 0);
    complete(2, 1, 0, 1, 1);
    chk("branch_taken", pc, 32'h0FC);

    fetch(32'h0000_0020, 1);
    complete(0, 1, 0, 0, 1);
    chk("seq_back", pc, 32'h100);

    // Branch not taken when Zero is low.
    fetch(32'h1000_FFFE, 0);
    complete(0, 2, 0, 1, 0);
    chk("branch_not_taken", pc, 32'h104);

    // Branch underflow to the top of the address space, then sequential wrap.
    fetch(32'h1000_FFBD, 1);
    complete(0, 1, 0, 1, 1);
    chk("branch_underflow", pc, 32'hFFFF_FFFC);
    fetch(32'h0000_0000, 0);
    complete(1, 2, 0, 0, 0);
    chk("seq_wrap", pc, 32'h0000_0000);

`ifdef FETCH_TIMEOUT_EN
    // No data for TIMEOUT wait cycles: error pulse and re-request.
    chk("to_addr", imem_addr, mpc);
    imem_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk1("to_wait_err", fetch_err, 1'b0);
      chk1("to_wait_req", imem_req, 1'b0);
      imem_valid = 1'b0;
      @(negedge clk);
    end
    chk1("to_err_pulse", fetch_err, 1'b1);
    chk1("to_rereq", imem_req, 1'b1);
    chk("to_rereq_addr", imem_addr, mpc);
    fetch(32'h0000_0000, 3);
    complete(0, 1, 0, 0, 0);
`else
    // Without the limit a long wait produces no error and no re-request.
    fetch(32'h0000_0000, 20);
    complete(0, 1, 0, 0, 0);
`endif

    // Randomized sequences.
    for (int n = 0; n < 40; n++) begin
      fetch($urandom, $urandom_range(0, 3));
      complete($urandom_range(0, 2), $urandom_range(1, 3),
               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a wait abandons the fetch.
    imem_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_pc", pc, 32'h100);
    chk1("mid_rst_iv", instr_valid, 1'b0);
    chk1("mid_rst_req", imem_req, 1'b0);
    chk1("mid_rst_err", fetch_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    mpc = 32'h100;
    @(negedge clk);
    chk1("mid_rst_rereq", imem_req, 1'b1);
    chk("mid_rst_addr", imem_addr, 32'h100);
    chk1("mid_rst_iv_after", instr_valid, 1'b0);
    fetch(32'h2008_0005, 1);
    complete(0, 1, 0, 0, 0);
    chk("mid_rst_seq", pc, 32'h104);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
